uart_tx_buffer: RTL and testbench

- Byte FIFO between the processor output path and the UART transmitter.
- Accepts bytes in single-cycle writes and drains them one frame at a time through the transmitter's data_tx / start_transmit / tx_ready handshake.
- Holds data_tx stable for the whole frame, because the transmitter samples it bit by bit.

---
 rtl/uart_tx_buffer.sv | 108 ++++++++++
 tb/tb_uart_tx_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter: accepts single-cycle writes and launches one
// frame at a time over the data_tx / start_transmit / tx_ready handshake.
module uart_tx_buffer #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [7:0]            data_tx,
    output logic                  start_transmit,
    input  logic                  tx_ready,
    output logic                  idle
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } state_t;

    state_t                  state;
    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic                    wr_accept;
    logic                    pop;

    assign full      = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign idle      = (state == IDLE) && empty;
    assign wr_accept = wr_en && !full;
    assign pop       = (state == IDLE) && !empty && tx_ready;

    // NOTE: the storage array has no reset; only the pointers and count define valid data.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // A write while full is dropped even if a pop frees a slot on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else if (wr_accept) begin
            wr_ptr <= wr_ptr + 1'b1;
        end else if (wr_en) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else begin
            case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // data_tx is loaded only when leaving IDLE, so it stays stable for the whole frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            data_tx        <= 8'h00;
            start_transmit <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_tx        <= mem[rd_ptr];
                        rd_ptr         <= rd_ptr + 1'b1;
                        start_transmit <= 1'b1;
                        state          <= START;
                    end
                end
                START: begin
                    if (!tx_ready) begin
                        start_transmit <= 1'b0;
                        state          <= BUSY;
                    end
                end
                BUSY: begin
                    if (tx_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    start_transmit <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: a queue-based reference of the byte stream plus a simple
// behavioural UART that drops tx_ready after a launch and raises it when the frame ends.
module tb_uart_tx_buffer;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   wr_data = 8'h00;
    logic         wr_en = 1'b0;
    logic         full;
    logic         empty;
    logic [4:0]   count;
    logic         overflow;
    logic [7:0]   data_tx;
    logic         start_transmit;
    logic         tx_ready = 1'b1;
    logic         idle;

    uart_tx_buffer #(.DEPTH_LOG2(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .data_tx        (data_tx),
        .start_transmit (start_transmit),
        .tx_ready       (tx_ready),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    logic [7:0] q[$];
    bit         m_over;
    bit         st_prev;
    logic [7:0] last_tx;
    bit         line;
    bit         hold_low;
    int         u_delay;
    int         u_low;
    int         frame_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_over   = 1'b0;
        st_prev  = 1'b0;
        last_tx  = 8'h00;
        line     = 1'b1;
        hold_low = 1'b0;
        u_delay  = 0;
        u_low    = 0;
    endtask

    // One clock: drive inputs, advance past the edge, then score the outputs.
    task automatic cycle(input bit we, input logic [7:0] d);
        bit         full_before;
        bit         txr;
        bit         st_rise;
        bit         st_fall;
        logic [7:0] exp_b;
        wr_en       = we;
        wr_data     = d;
        txr         = hold_low ? 1'b0 : line;
        tx_ready    = txr;
        full_before = (q.size() == 16);
        @(posedge clk);
        #1;
        st_rise = start_transmit && !st_prev;
        st_fall = !start_transmit && st_prev;
        if (st_rise) begin
            check("pop_with_ready", txr, 1);
            check("pop_nonempty", (q.size() > 0), 1);
            if (q.size() > 0) begin
                exp_b = q.pop_front();
                check("data_order", data_tx, exp_b);
                last_tx = exp_b;
            end else begin
                last_tx = data_tx;
            end
        end else begin
            check("data_hold", data_tx, last_tx);
        end
        if (st_fall) check("start_drop_on_busy", txr, 0);
        if (we) begin
            if (!full_before) q.push_back(d);
            else m_over = 1'b1;
        end
        check("count", count, q.size());
        check("full", full, (q.size() == 16));
        check("empty", empty, (q.size() == 0));
        check("overflow", overflow, m_over);
        st_prev = start_transmit;
        if (st_rise) begin
            u_delay = 3;
        end else if (u_delay > 0) begin
            u_delay--;
            if (u_delay == 0) begin
                line  = 1'b0;
                u_low = frame_len;
            end
        end else if (u_low > 0) begin
            u_low--;
            if (u_low == 0) line = 1'b1;
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (!(idle && q.size() == 0 && line && u_delay == 0 && u_low == 0) && n < limit) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("drain_in_time", (n < limit), 1);
    endtask

    initial begin
        int sent;
        int n;
        bit we;
        model_reset();
        frame_len = 80;

        #2 reset = 1'b0;
        #10;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_start", start_transmit, 0);
        check("rst_data_tx", data_tx, 0);
        check("rst_idle", idle, 1);
        @(negedge clk);
        reset = 1'b1;

        // Single byte: launch two edges after the write, frame completes, back to idle.
        cycle(1'b1, 8'h41);
        check("t1_empty_after_write", empty, 0);
        check("t1_no_start_yet", start_transmit, 0);
        cycle(1'b0, 8'h00);
        check("t1_start_high", start_transmit, 1);
        check("t1_data_tx", data_tx, 8'h41);
        drain(400);
        check("t1_idle", idle, 1);

        // Fill to capacity while the UART is busy elsewhere; 17th write is dropped.
        hold_low = 1'b1;
        for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i));
        check("t2_full", full, 1);
        check("t2_count16", count, 16);
        cycle(1'b1, 8'hFF);
        check("t2_overflow", overflow, 1);
        check("t2_count_still16", count, 16);
        check("t2_no_start", start_transmit, 0);
        hold_low = 1'b0;
        drain(16 * 120);

        // tx_ready low while data is queued: nothing moves until it rises.
        hold_low = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'($urandom));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 8'h00);
            check("t5_no_start", start_transmit, 0);
            check("t5_count3", count, 3);
        end
        hold_low = 1'b0;
        cycle(1'b0, 8'h00);
        check("t5_pop_on_ready", start_transmit, 1);
        check("t5_count2", count, 2);
        drain(3 * 120);

        // Streaming writes alongside draining frames; pointers wrap several times.
        frame_len = 6;
        sent = 0;
        n = 0;
        while (sent < 40 && n < 5000) begin
            we = (q.size() < 15);
            cycle(we, 8'($urandom));
            if (we) sent++;
            n++;
        end
        check("t3_all_written", sent, 40);
        drain(40 * 30);

        // Asynchronous reset between edges while a frame is in flight.
        frame_len = 20;
        cycle(1'b1, 8'hA1);
        cycle(1'b1, 8'hA2);
        cycle(1'b1, 8'hA3);
        n = 0;
        while (!(line == 1'b0 && !start_transmit) && n < 50) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        check("t4_reached_busy", (n < 50), 1);
        #3 reset = 1'b0;
        #1;
        check("t4_rst_start", start_transmit, 0);
        check("t4_rst_count", count, 0);
        check("t4_rst_empty", empty, 1);
        check("t4_rst_data_tx", data_tx, 0);
        check("t4_rst_idle", idle, 1);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        cycle(1'b1, 8'h5A);
        cycle(1'b0, 8'h00);
        check("t4_restart_start", start_transmit, 1);
        check("t4_restart_data", data_tx, 8'h5A);
        drain(200);

        // Random traffic with occasional tx_ready holds and varying frame length.
        frame_len = int'($urandom_range(2, 12));
        for (int i = 0; i < 400; i++) begin
            hold_low = ($urandom_range(0, 9) == 0);
            cycle(1'($urandom_range(0, 1)), 8'($urandom));
        end
        hold_low = 1'b0;
        drain(16 * 40);
        check("final_idle", idle, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
